// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial slave bus master.
//  - read_write_slave_e : R/W bit of the control frame
//  - top_master_burst_e : B bit of the control frame
//  - state_e            : master sequencer states
//  - START_PATTERN      : leading bits of every control frame
package serial_bus_pkg;

    localparam int unsigned START_W       = 3;
    localparam logic [2:0]  START_PATTERN = 3'b111;

    typedef enum logic {
        Read_slave  = 1'b0,
        Write_slave = 1'b1
    } read_write_slave_e;

    typedef enum logic {
        non_burst    = 1'b0,
        burst_master = 1'b1
    } top_master_burst_e;

    typedef enum logic [2:0] {
        IDLE,
        FRAME,
        WAIT_RDY,
        XFER,
        DONE
    } state_e;

    // Control frame length: start pattern, slave id, R/W, B, address.
    function automatic int unsigned frame_len(input int unsigned id_w, input int unsigned addr_w);
        return START_W + id_w + 2 + addr_w;
    endfunction

endpackage

// File: rtl/serial_bus_master_ctrl_if.sv
// Request-side and serial-bus-side signals of the bus master.
//  master modport : the sequencer (drives strobes, status and serial outputs)
//  slave  modport : local logic plus bus/slave model (drives request, wr_data, rD, ready)
interface serial_bus_master_ctrl_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned SLAVE_ID_W    = 2,
    parameter int unsigned MAX_BURST     = 256
);
    localparam int unsigned LEN_W = $clog2(MAX_BURST + 1);

    // local request side
    logic                     req;
    logic                     req_write;
    logic                     req_burst;
    logic [SLAVE_ID_W-1:0]    req_slave_id;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [LEN_W-1:0]         req_len;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     wr_data_req;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_data_valid;
    logic                     busy;
    logic                     done;

    // serial bus side
    logic                     control;
    logic                     wD;
    logic                     valid;
    logic                     last;
    logic                     rD;
    logic                     ready;

    modport master (
        input  req, req_write, req_burst, req_slave_id, req_addr, req_len, wr_data,
        input  rD, ready,
        output wr_data_req, rd_data, rd_data_valid, busy, done,
        output control, wD, valid, last
    );

    modport slave (
        output req, req_write, req_burst, req_slave_id, req_addr, req_len, wr_data,
        output rD, ready,
        input  wr_data_req, rd_data, rd_data_valid, busy, done,
        input  control, wD, valid, last
    );

endinterface

// File: rtl/serial_shift_reg.sv
// Loadable shift register, MSB first, with a shift counter.
//  load/load_val : parallel load, clears the counter (load wins over shift)
//  shift/sin     : shift left one bit, sin enters at bit 0
//  par           : register contents; par[WIDTH-1] is the serial output
//  last_bit_c    : current shift is the WIDTH-th since load
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] par,
    output logic             last_bit_c
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sreg_q;
    logic [CNT_W-1:0] cnt_q;

    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
    assign par        = sreg_q;

    // Shifter and bit counter; counter wraps after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sreg_q <= load_val;
            cnt_q  <= '0;
        end else if (shift) begin
            sreg_q <= {sreg_q[WIDTH-2:0], sin};
            cnt_q  <= last_bit_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_bus_master_ctrl.sv
// Master-side transaction sequencer for the serial slave bus.
// Latches a parallel request, serialises the control frame
// '111'|slave_id|R/W|B|address on control, then moves each data word
// (write on wD, read from rD) gated by slave ready between words.
//  clk, rstN : clock, asynchronous active-low reset
//  bus       : request side (req*, wr_data/wr_data_req, rd_data/rd_data_valid,
//              busy, done) and serial side (control, wD, valid, last, rD, ready)
module serial_bus_master_ctrl
    import serial_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned SLAVE_ID_W    = 2,
    parameter int unsigned MAX_BURST     = 256
) (
    input  logic                     clk,
    input  logic                     rstN,
    serial_bus_master_ctrl_if.master bus
);
    localparam int unsigned LEN_W     = $clog2(MAX_BURST + 1);
    localparam int unsigned FRAME_LEN = frame_len(SLAVE_ID_W, ADDRESS_WIDTH);

    state_e                  state_q, state_d;
    read_write_slave_e       rw_q;
    logic [LEN_W-1:0]        words_q;
    logic [LEN_W-1:0]        words_init_c;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    rdv_q, rdv_d;

    logic                    frm_load_c, frm_shift_c, frm_last_c;
    logic                    dat_load_c, dat_shift_c, dat_last_c;
    logic                    wr_data_req_c;
    logic [FRAME_LEN-1:0]    frm_par;
    logic [FRAME_LEN-1:0]    frm_init_c;
    logic [DATA_WIDTH-1:0]   dat_par;
    logic [DATA_WIDTH-1:0]   dat_init_c;

    assign frm_init_c = {START_PATTERN, bus.req_slave_id, bus.req_write, bus.req_burst, bus.req_addr};
    // Reads load zeros so the shifter only ever holds the incoming word.
    assign dat_init_c = (rw_q == Write_slave) ? bus.wr_data : '0;

    // A zero length or a non-burst request moves exactly one word.
    assign words_init_c = (top_master_burst_e'(bus.req_burst) == burst_master && bus.req_len != '0)
                          ? bus.req_len : LEN_W'(1);

    // Control frame shifter: zeros shift in behind the frame so control idles low.
    serial_shift_reg #(.WIDTH(FRAME_LEN)) u_frame_sr (
        .clk        (clk),
        .rst_n      (rstN),
        .load       (frm_load_c),
        .load_val   (frm_init_c),
        .shift      (frm_shift_c),
        .sin        (1'b0),
        .par        (frm_par),
        .last_bit_c (frm_last_c)
    );

    // Data shifter: PISO for writes, SIPO from rD for reads.
    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
        .clk        (clk),
        .rst_n      (rstN),
        .load       (dat_load_c),
        .load_val   (dat_init_c),
        .shift      (dat_shift_c),
        .sin        (bus.rD),
        .par        (dat_par),
        .last_bit_c (dat_last_c)
    );

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            rdv_q   <= rdv_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.req)   state_d = FRAME;
            FRAME:    if (frm_last_c) state_d = WAIT_RDY;
            WAIT_RDY: if (bus.ready) state_d = XFER;
            XFER:     if (dat_last_c) state_d = (words_q == LEN_W'(1)) ? DONE : WAIT_RDY;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath-control decode.
    always_comb begin
        frm_load_c    = 1'b0;
        frm_shift_c   = 1'b0;
        dat_load_c    = 1'b0;
        dat_shift_c   = 1'b0;
        wr_data_req_c = 1'b0;
        rdv_d         = 1'b0;
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        valid_d       = (state_d == XFER);
        // words_q only changes on leaving XFER, so it is stable for the whole word.
        last_d        = (state_d == XFER) && (words_q == LEN_W'(1));
        case (state_q)
            IDLE:     frm_load_c = bus.req;
            FRAME:    frm_shift_c = 1'b1;
            WAIT_RDY: begin
                dat_load_c    = bus.ready;
                wr_data_req_c = bus.ready && (rw_q == Write_slave);
            end
            XFER: begin
                dat_shift_c = 1'b1;
                rdv_d       = dat_last_c && (rw_q == Read_slave);
            end
            default: ;
        endcase
    end

    // Request latch, remaining-word counter and read capture.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rw_q      <= Read_slave;
            words_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (frm_load_c) begin
                rw_q    <= read_write_slave_e'(bus.req_write);
                words_q <= words_init_c;
            end else if (dat_shift_c && dat_last_c) begin
                words_q <= words_q - LEN_W'(1);
            end
            // The final bit is still on rD; take it together with the shifted bits.
            if (rdv_d) begin
                rd_data_q <= {dat_par[DATA_WIDTH-2:0], bus.rD};
            end
        end
    end

    assign bus.control       = frm_par[FRAME_LEN-1];
    assign bus.wD            = valid_q && (rw_q == Write_slave) && dat_par[DATA_WIDTH-1];
    assign bus.valid         = valid_q;
    assign bus.last          = last_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rdv_q;
    assign bus.wr_data_req   = wr_data_req_c;

endmodule

// File: tb/tb_serial_bus_master_ctrl.sv
// Directed bench for serial_bus_master_ctrl with write/read/last scoreboards.
module tb_serial_bus_master_ctrl;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    serial_bus_master_ctrl_if bus ();

    serial_bus_master_ctrl dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_exp[$];
    logic [7:0] rd_exp[$];
    logic       last_exp[$];

    logic [7:0] wsrc[0:15];
    logic [7:0] rsrc[0:15];
    int         widx  = 0;
    int         wfill = 0;
    int         ridx  = 0;
    int         rfill = 0;
    int         rbit  = 0;
    bit         rd_mode = 1'b0;

    int done_cnt = 0;
    int rdv_cnt  = 0;
    int wreq_cnt = 0;
    int done0, rdv0, wreq0, k;

    logic [7:0] mw;
    int         mb = 0;
    logic       m_and, m_or, e1;
    logic [7:0] e8;
    logic [7:0] d;

    assign bus.wr_data = wsrc[widx];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops scoreboards as the DUT produces words.
    always begin
        @(negedge clk);
        #2;
        if (!rstN) mb = 0;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.rd_data_valid === 1'b1) begin
            rdv_cnt++;
            if (rd_exp.size() == 0) check("rd_unexpected", 32'(bus.rd_data_valid), 32'(0));
            else begin
                e8 = rd_exp.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(e8));
            end
        end
        if (bus.valid === 1'b1) begin
            if (mb == 0) begin
                m_and = 1'b1;
                m_or  = 1'b0;
            end
            mw    = {mw[6:0], bus.wD};
            m_and = m_and & bus.last;
            m_or  = m_or | bus.last;
            mb++;
            if (mb == 8) begin
                mb = 0;
                if (rd_mode) check("wD_during_read", 32'(mw), 32'(0));
                else if (wr_exp.size() == 0) check("wr_unexpected", 32'(bus.valid), 32'(0));
                else begin
                    e8 = wr_exp.pop_front();
                    check("wr_word", 32'(mw), 32'(e8));
                end
                if (last_exp.size() == 0) check("last_unexpected", 32'(bus.valid), 32'(0));
                else begin
                    e1 = last_exp.pop_front();
                    check("last_flag", 32'({m_and, m_or}), 32'({e1, e1}));
                end
            end
        end
        if (bus.wr_data_req === 1'b1) begin
            wreq_cnt++;
            @(posedge clk);
            #1;
            widx++;
        end
    end

    // Slave read-data model: one bit per valid cycle, MSB first.
    initial begin
        bus.rD = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.valid === 1'b1 && rd_mode) begin
                bus.rD = rsrc[ridx][7-rbit];
                rbit++;
                if (rbit == 8) begin
                    rbit = 0;
                    ridx++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input logic wr, input logic burst, input logic [1:0] id,
                             input logic [11:0] addr, input logic [8:0] len);
        bus.req          = 1'b1;
        bus.req_write    = wr;
        bus.req_burst    = burst;
        bus.req_slave_id = id;
        bus.req_addr     = addr;
        bus.req_len      = len;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] v, input logic lst);
        wsrc[wfill] = v;
        wfill++;
        wr_exp.push_back(v);
        last_exp.push_back(lst);
    endtask

    task automatic push_rd(input logic [7:0] v, input logic lst);
        rsrc[rfill] = v;
        rfill++;
        rd_exp.push_back(v);
        last_exp.push_back(lst);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(bus.done), 32'(1));
        @(negedge clk);
        check("idle_after_done", 32'({bus.busy, bus.done}), 32'(0));
    endtask

    task automatic check_frame(input logic [18:0] f);
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clk);
            check("frame_bit", 32'(bus.control), 32'(f[18-i]));
            check("frame_busy", 32'({bus.busy, bus.valid}), 32'(2'b10));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            wsrc[i] = 8'h00;
            rsrc[i] = 8'h00;
        end
        rstN             = 1'b0;
        bus.req          = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_burst    = 1'b0;
        bus.req_slave_id = '0;
        bus.req_addr     = '0;
        bus.req_len      = '0;
        bus.ready        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({bus.busy, bus.done, bus.control, bus.wD, bus.valid, bus.last,
                                  bus.wr_data_req, bus.rd_data_valid}), 32'(0));
        check("rst_rd_data", 32'(bus.rd_data), 32'(0));
        rstN = 1'b1;
        @(negedge clk);

        // 1: single write, cycle-exact
        rd_mode = 1'b0;
        push_wr(8'hA5, 1'b1);
        drive_req(1'b1, 1'b0, 2'd1, 12'h0AB, 9'd0);
        check_frame({3'b111, 2'b01, 1'b1, 1'b0, 12'h0AB});
        @(negedge clk);
        check("t1_wreq_cycle", 32'({bus.control, bus.wr_data_req, bus.valid}), 32'(3'b010));
        d = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_xfer_bit", 32'({bus.valid, bus.last, bus.wD}), 32'({2'b11, d[7-i]}));
        end
        @(negedge clk);
        check("t1_done", 32'({bus.done, bus.busy, bus.valid}), 32'(3'b110));
        @(negedge clk);
        check("t1_idle", 32'({bus.busy, bus.done}), 32'(0));
        check("t1_wreq_count", 32'(wreq_cnt), 32'(1));
        check("t1_done_count", 32'(done_cnt), 32'(1));

        // 2: burst read of four words
        rd_mode = 1'b1;
        push_rd(8'h11, 1'b0);
        push_rd(8'h22, 1'b0);
        push_rd(8'h33, 1'b0);
        push_rd(8'h44, 1'b1);
        done0 = done_cnt; rdv0 = rdv_cnt;
        drive_req(1'b0, 1'b1, 2'd2, 12'h000, 9'd4);
        wait_done(400);
        check("t2_rdv_count", 32'(rdv_cnt - rdv0), 32'(4));
        check("t2_done_count", 32'(done_cnt - done0), 32'(1));
        check("t2_rd_hold", 32'(bus.rd_data), 32'(8'h44));

        // 3: burst write with a 5-cycle ready stall after word 1
        rd_mode = 1'b0;
        push_wr(8'h3C, 1'b0);
        push_wr(8'hC3, 1'b0);
        push_wr(8'h5A, 1'b1);
        done0 = done_cnt; wreq0 = wreq_cnt;
        drive_req(1'b1, 1'b1, 2'd0, 12'h123, 9'd3);
        k = 0;
        while (bus.valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("t3_word1_start", 32'(bus.valid), 32'(1));
        bus.ready = 1'b0;
        k = 0;
        while (bus.valid === 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("t3_word1_end", 32'(bus.valid), 32'(0));
        for (int i = 0; i < 5; i++) begin
            check("t3_stall", 32'({bus.valid, bus.wr_data_req}), 32'(0));
            @(negedge clk);
        end
        bus.ready = 1'b1;
        #1;
        check("t3_wreq_on_ready", 32'(bus.wr_data_req), 32'(1));
        @(negedge clk);
        check("t3_word2_start", 32'(bus.valid), 32'(1));
        wait_done(200);
        check("t3_wreq_count", 32'(wreq_cnt - wreq0), 32'(3));
        check("t3_done_count", 32'(done_cnt - done0), 32'(1));

        // 4: reset in frame cycle 10, then a full new frame
        done0 = done_cnt;
        drive_req(1'b1, 1'b0, 2'd1, 12'h555, 9'd0);
        repeat (9) @(negedge clk);
        rstN = 1'b0;
        #1;
        check("t4_rst_outputs", 32'({bus.busy, bus.done, bus.control, bus.wD, bus.valid, bus.last,
                                     bus.wr_data_req, bus.rd_data_valid}), 32'(0));
        check("t4_rst_rd_data", 32'(bus.rd_data), 32'(0));
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_no_done", 32'(done_cnt - done0), 32'(0));
        check("t4_idle", 32'(bus.busy), 32'(0));
        rd_mode = 1'b1;
        push_rd(8'h96, 1'b1);
        rdv0 = rdv_cnt;
        drive_req(1'b0, 1'b0, 2'd3, 12'hFFF, 9'd0);
        check_frame({3'b111, 2'b11, 1'b0, 1'b0, 12'hFFF});
        wait_done(100);
        check("t4_rdv_count", 32'(rdv_cnt - rdv0), 32'(1));

        // 5: zero burst length and ignored length on non-burst
        rd_mode = 1'b0;
        push_wr(8'h81, 1'b1);
        wreq0 = wreq_cnt;
        drive_req(1'b1, 1'b1, 2'd0, 12'h010, 9'd0);
        wait_done(100);
        check("t5_len0_words", 32'(wreq_cnt - wreq0), 32'(1));
        rd_mode = 1'b1;
        push_rd(8'h7E, 1'b1);
        rdv0 = rdv_cnt;
        drive_req(1'b0, 1'b0, 2'd1, 12'h020, 9'd5);
        wait_done(100);
        check("t5_nonburst_words", 32'(rdv_cnt - rdv0), 32'(1));

        // 6: req during busy ignored; back-to-back accept after done
        rd_mode = 1'b0;
        push_wr(8'h42, 1'b1);
        done0 = done_cnt; wreq0 = wreq_cnt; rdv0 = rdv_cnt;
        drive_req(1'b1, 1'b0, 2'd2, 12'h0F0, 9'd0);
        repeat (4) @(negedge clk);
        bus.req       = 1'b1;
        bus.req_write = 1'b0;
        bus.req_burst = 1'b1;
        bus.req_len   = 9'd7;
        @(negedge clk);
        bus.req = 1'b0;
        wait_done(100);
        check("t6_ignored_wreq", 32'(wreq_cnt - wreq0), 32'(1));
        check("t6_ignored_done", 32'(done_cnt - done0), 32'(1));
        check("t6_ignored_rdv", 32'(rdv_cnt - rdv0), 32'(0));
        push_wr(8'h0F, 1'b0);
        push_wr(8'hF0, 1'b1);
        drive_req(1'b1, 1'b1, 2'd1, 12'h321, 9'd2);
        check("t6_b2b_accept", 32'(bus.busy), 32'(1));
        wait_done(200);
        check("t6_total_wreq", 32'(wreq_cnt - wreq0), 32'(3));
        check("t6_total_done", 32'(done_cnt - done0), 32'(2));

        repeat (3) @(negedge clk);
        check("wr_exp_drained", 32'(wr_exp.size()), 32'(0));
        check("rd_exp_drained", 32'(rd_exp.size()), 32'(0));
        check("last_exp_drained", 32'(last_exp.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
